// File: rtl/reg_scoreboard.sv
// Dual-issue register hazard scoreboard for the Decode stage.
// Per-register pending-write counters gate issue of slots A and B against RAW/WAW hazards.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validA,
    input  logic [4:0]  ra1A,
    input  logic [4:0]  ra2A,
    input  logic        regwrA,
    input  logic [4:0]  waA,
    input  logic        validB,
    input  logic [4:0]  ra1B,
    input  logic [4:0]  ra2B,
    input  logic        regwrB,
    input  logic [4:0]  waB,
    input  logic        advance,
    input  logic        wbEnA,
    input  logic [4:0]  wbAddrA,
    input  logic        wbEnB,
    input  logic [4:0]  wbAddrB,
    output logic        grantA,
    output logic        grantB,
    output logic [31:0] busy
);

    localparam int              NREG = 32;
    localparam int              SW   = CNT_W + 2;
    localparam logic [CNT_W-1:0] MAX = '1;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             underflow;
        logic             overflow;
    } cnt_upd_t;

    // Net change is computed in a wider field so that a negative or over-MAX
    // result is detected instead of wrapping.
    function automatic cnt_upd_t update_cnt(input logic [CNT_W-1:0] cur,
                                            input logic inc_a, input logic inc_b,
                                            input logic dec_a, input logic dec_b);
        cnt_upd_t         res;
        logic [SW-1:0]    up;
        logic [SW-1:0]    down;
        logic [SW-1:0]    net;
        up            = SW'(cur) + SW'(inc_a) + SW'(inc_b);
        down          = SW'(dec_a) + SW'(dec_b);
        net           = up - down;
        res.underflow = (up < down);
        res.overflow  = !res.underflow && (net > SW'(MAX));
        if (res.underflow) begin
            res.cnt = '0;
        end else if (res.overflow) begin
            res.cnt = MAX;
        end else begin
            res.cnt = CNT_W'(net);
        end
        return res;
    endfunction

    logic [CNT_W-1:0]                cnt_q [1:NREG-1];
    logic [CNT_W-1:0]                cnt_d [1:NREG-1];
    logic [NREG-1:0][CNT_W-1:0]      cnt_view;
    logic [NREG-1:1]                 underflow;
    logic [NREG-1:1]                 overflow;

    logic          sat_a;
    logic          sat_b;
    logic          pair_dep;
    logic          haz_a;
    logic          haz_b;
    logic          fire_a;
    logic          fire_b;
    logic [SW-1:0] b_need;

    // Register 0 has no counter; the flat view reads it as zero so address 0
    // can index it like any other register.
    always_comb begin
        cnt_view = '0;
        busy     = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_view[r] = cnt_q[r];
            busy[r]     = (cnt_q[r] != '0);
        end
    end

    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        sat_a    = 1'b0;
        sat_b    = 1'b0;
        pair_dep = 1'b0;
        b_need   = '0;

        sat_a    = regwrA && (cnt_view[waA] == MAX);
        // B's write lands behind A's when both target the same register.
        b_need   = SW'(cnt_view[waB]) + SW'(regwrA && (waA == waB)) + SW'(1);
        sat_b    = regwrB && (waB != 5'd0) && (b_need > SW'(MAX));
        pair_dep = regwrA && (waA != 5'd0) && ((ra1B == waA) || (ra2B == waA));

        haz_a    = busy[ra1A] || busy[ra2A] || sat_a;
        haz_b    = busy[ra1B] || busy[ra2B] || pair_dep || sat_b;

        grantA   = validA && !haz_a;
        grantB   = validB && grantA && !haz_b;
        fire_a   = grantA && advance;
        fire_b   = grantB && advance;
    end

    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            cnt_upd_t upd;
            upd = update_cnt(cnt_q[r],
                             fire_a && regwrA && (waA == 5'(r)),
                             fire_b && regwrB && (waB == 5'(r)),
                             wbEnA && (wbAddrA == 5'(r)),
                             wbEnB && (wbAddrB == 5'(r)));
            cnt_d[r]     = upd.cnt;
            underflow[r] = upd.underflow;
            overflow[r]  = upd.overflow;
        end
    end

    // NOTE: the counter array is real state that must start from zero, so every
    // entry is reset, and state updates use non-blocking assignment only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Retiring a register with no pending write is a protocol error from
    // Writeback; the counter holds at zero and the event is flagged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 1; r < NREG; r++) begin
                assert (!underflow[r])
                    else $warning("reg_scoreboard: writeback underflow on r%0d", r);
                assert (!overflow[r])
                    else $error("reg_scoreboard: pending counter overflow on r%0d", r);
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hand-computed grants and busy vectors
// across RAW, intra-pair, WAW/saturation, inc/dec overlap, r0 and reset cases.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        validA, regwrA, validB, regwrB, advance, wbEnA, wbEnB;
    logic [4:0]  ra1A, ra2A, waA, ra1B, ra2B, waB, wbAddrA, wbAddrB;
    logic        grantA, grantB;
    logic [31:0] busy;

    int checks   = 0;
    int failures = 0;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .validA  (validA),
        .ra1A    (ra1A),
        .ra2A    (ra2A),
        .regwrA  (regwrA),
        .waA     (waA),
        .validB  (validB),
        .ra1B    (ra1B),
        .ra2B    (ra2B),
        .regwrB  (regwrB),
        .waB     (waB),
        .advance (advance),
        .wbEnA   (wbEnA),
        .wbAddrA (wbAddrA),
        .wbEnB   (wbEnB),
        .wbAddrB (wbAddrB),
        .grantA  (grantA),
        .grantB  (grantB),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            end
    endtask

    task automatic drive_a(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic wr, input logic [4:0] wa);
        validA = v; ra1A = r1; ra2A = r2; regwrA = wr; waA = wa;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic wr, input logic [4:0] wa);
        validB = v; ra1B = r1; ra2B = r2; regwrB = wr; waB = wa;
    endtask

    task automatic drive_wb(input logic ea, input logic [4:0] aa,
                            input logic eb, input logic [4:0] ab);
        wbEnA = ea; wbAddrA = aa; wbEnB = eb; wbAddrB = ab;
    endtask

    task automatic idle();
        drive_a(1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        drive_b(1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
        advance = 1'b0;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        check("reset_busy", busy, 32'h0);
        reset = 1'b0;

        // Idle issue with clean sources.
        drive_a(1'b1, 5'd1, 5'd2, 1'b0, 5'd0);
        drive_b(1'b1, 5'd1, 5'd2, 1'b0, 5'd0);
        advance = 1'b1;
        settle();
        check("idle_grantA", 32'(grantA), 32'd1);
        check("idle_grantB", 32'(grantB), 32'd1);
        tick();
        check("idle_busy", busy, 32'h0);

        // RAW across cycles on r5.
        drive_a(1'b1, 5'd1, 5'd2, 1'b1, 5'd5);
        drive_b(1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        settle();
        check("raw_issue_grantA", 32'(grantA), 32'd1);
        tick();
        check("raw_busy5", busy, 32'h0000_0020);
        drive_a(1'b1, 5'd5, 5'd2, 1'b0, 5'd0);
        drive_b(1'b1, 5'd1, 5'd2, 1'b0, 5'd0);
        settle();
        check("raw_stall_grantA", 32'(grantA), 32'd0);
        check("raw_stall_grantB", 32'(grantB), 32'd0);
        tick();
        settle();
        check("raw_stall2_grantA", 32'(grantA), 32'd0);
        tick();
        drive_wb(1'b1, 5'd5, 1'b0, 5'd0);
        settle();
        check("raw_wb_no_bypass", 32'(grantA), 32'd0);
        tick();
        drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check("raw_release_grantA", 32'(grantA), 32'd1);
        check("raw_release_grantB", 32'(grantB), 32'd1);
        check("raw_release_busy", busy, 32'h0);
        tick();

        // Intra-pair dependency: B reads the register A writes.
        drive_a(1'b1, 5'd1, 5'd2, 1'b1, 5'd7);
        drive_b(1'b1, 5'd1, 5'd7, 1'b0, 5'd0);
        settle();
        check("pair_grantA", 32'(grantA), 32'd1);
        check("pair_grantB", 32'(grantB), 32'd0);
        tick();
        check("pair_busy7", busy, 32'h0000_0080);
        idle();
        drive_wb(1'b1, 5'd7, 1'b0, 5'd0);
        tick();
        check("pair_retire7", busy, 32'h0);

        // WAW and saturation on r9.
        drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
        drive_a(1'b1, 5'd1, 5'd2, 1'b1, 5'd9);
        drive_b(1'b1, 5'd1, 5'd2, 1'b1, 5'd9);
        advance = 1'b1;
        settle();
        check("waw1_grantA", 32'(grantA), 32'd1);
        check("waw1_grantB", 32'(grantB), 32'd1);
        tick();
        check("waw1_busy9", busy, 32'h0000_0200);
        settle();
        check("waw2_grantA", 32'(grantA), 32'd1);
        check("waw2_grantB_sat", 32'(grantB), 32'd0);
        tick();
        settle();
        check("waw3_grantA_sat", 32'(grantA), 32'd0);
        check("waw3_grantB_sat", 32'(grantB), 32'd0);
        tick();
        idle();
        drive_wb(1'b1, 5'd9, 1'b1, 5'd9);
        tick();
        check("waw_dual_wb_busy9", busy, 32'h0000_0200);
        drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
        drive_a(1'b1, 5'd1, 5'd2, 1'b1, 5'd9);
        drive_b(1'b1, 5'd1, 5'd2, 1'b1, 5'd9);
        settle();
        check("waw_cnt1_grantA", 32'(grantA), 32'd1);
        check("waw_cnt1_grantB", 32'(grantB), 32'd1);
        idle();
        drive_wb(1'b1, 5'd9, 1'b0, 5'd0);
        tick();
        check("waw_drain_busy", busy, 32'h0);

        // Simultaneous increment and decrement on r4.
        drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
        drive_a(1'b1, 5'd1, 5'd2, 1'b1, 5'd4);
        advance = 1'b1;
        tick();
        check("incdec_setup_busy4", busy, 32'h0000_0010);
        drive_wb(1'b0, 5'd0, 1'b1, 5'd4);
        settle();
        check("incdec_grantA", 32'(grantA), 32'd1);
        tick();
        check("incdec_busy4", busy, 32'h0000_0010);
        idle();
        drive_wb(1'b1, 5'd4, 1'b0, 5'd0);
        tick();
        check("incdec_drain_busy", busy, 32'h0);

        // Register 0 is never tracked.
        drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
        drive_a(1'b1, 5'd0, 5'd0, 1'b1, 5'd0);
        drive_b(1'b1, 5'd0, 5'd0, 1'b1, 5'd0);
        advance = 1'b1;
        settle();
        check("r0_write_grantA", 32'(grantA), 32'd1);
        check("r0_write_grantB", 32'(grantB), 32'd1);
        tick();
        check("r0_busy", busy, 32'h0);
        drive_a(1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        drive_b(1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        settle();
        check("r0_read_grantA", 32'(grantA), 32'd1);
        check("r0_read_grantB", 32'(grantB), 32'd1);
        tick();

        // Reset mid-flight with two writes pending on r3.
        drive_a(1'b1, 5'd1, 5'd2, 1'b1, 5'd3);
        drive_b(1'b1, 5'd1, 5'd2, 1'b1, 5'd3);
        settle();
        check("rst_setup_grantB", 32'(grantB), 32'd1);
        tick();
        check("rst_setup_busy3", busy, 32'h0000_0008);
        idle();
        reset = 1'b1;
        settle();
        check("rst_async_busy", busy, 32'h0);
        tick();
        reset = 1'b0;
        drive_wb(1'b1, 5'd3, 1'b0, 5'd0);
        tick();
        check("rst_underflow_busy", busy, 32'h0);
        drive_wb(1'b0, 5'd0, 1'b0, 5'd0);
        drive_a(1'b1, 5'd1, 5'd2, 1'b1, 5'd3);
        drive_b(1'b1, 5'd1, 5'd2, 1'b1, 5'd3);
        settle();
        check("rst_nowrap_grantA", 32'(grantA), 32'd1);
        check("rst_nowrap_grantB", 32'(grantB), 32'd1);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Dual-issue hazard scoreboard in the Decode stage, alongside the dual-port register file.
- Tracks in-flight writes to each architectural register with a per-register pending counter.
- Grants or stalls issue slots A and B based on RAW/WAW hazards and the intra-pair dependency.
- Counters increment on issue and decrement when the Writeback stage drives the register file write ports (weA/weB).

Parameters:
- CNT_W, 2, width of each per-register pending counter; MAX = 2^CNT_W - 1 outstanding writes per register.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous active-high reset.
- validA  in  1  slot A holds a decoded instruction.
- ra1A, ra2A  in  5 each  slot A source registers; register 0 is never a hazard.
- regwrA  in  1  slot A writes a destination register.
- waA  in  5  slot A destination register.
- validB, ra1B, ra2B, regwrB, waB  in  1/5/5/1/5  same fields for slot B (younger instruction).
- advance  in  1  decode stage moves forward this cycle (no external stall).
- wbEnA, wbEnB  in  1 each  writeback port A/B retires a write (mirrors register file weA/weB).
- wbAddrA, wbAddrB  in  5 each  retiring destination register.
- grantA  out  1  slot A may issue this cycle (combinational).
- grantB  out  1  slot B may issue this cycle (combinational).
- busy  out  32  bit r = (cnt[r] != 0), registered view; bit 0 always 0.

Behaviour:
- State: cnt[1..31], each CNT_W bits. cnt[0] does not exist and reads as 0.
- Reset (async, reset=1): all cnt cleared to 0, busy = 0. grantA/grantB then follow their equations with all counters zero.
- hazA = ra1A busy or ra2A busy, or (regwrA and cnt[waA] == MAX). Here "busy" means cnt != 0 and reg != 0.
- grantA = validA and not hazA.
- hazB = ra1B or ra2B busy, or (regwrA and waA != 0 and (ra1B == waA or ra2B == waA)), or a saturation check on waB.
- Saturation check on waB: cnt[waB] + (regwrA and waA == waB ? 1 : 0) + 1 > MAX.
- grantB = validB and grantA and not hazB. Issue is in order: B never issues without A.
- Same-cycle writeback does not bypass the hazard check. A register retiring this cycle still reads busy; the grant arrives one cycle later. Latency of release: 1 cycle after the wbEn edge.
- Fire: fireA = grantA and advance; fireB = grantB and advance.
- Per-register next-state for r != 0: cnt[r] += incA + incB - decA - decB.
  - incA = fireA and regwrA and waA == r; incB likewise.
  - decA = wbEnA and wbAddrA == r; decB likewise.
  - Signed net in [-2, +2]; the result is written with no wrap.
- Both writebacks targeting the same r: decrement by 2.
- Decrement when cnt[r] == 0: protocol error. Counter holds at 0 (saturating) and never underflows; a simulation assertion fires.
- Increment beyond MAX is impossible by construction (grant equations). A simulation assertion checks it.
- Writes or issues to register 0 are ignored.
- busy is derived from the registered cnt, so there is no combinational path from wb* to grant*.
- Reset asserted mid-operation clears all counters immediately. In-flight writebacks after reset are treated as underflow and ignored.

Test Plan:
- Reset then idle: reset=1 -> busy=0; with validA=validB=1, all sources r1/r2, no writes -> grantA=grantB=1.
- RAW across cycles:
  - Cycle 0: A issues with regwrA=1, waA=5. Cycle 1: A reads ra1A=5 -> grantA=0, grantB=0, busy[5]=1.
  - wbEnA=1, wbAddrA=5 in cycle 3 -> grantA=1 in cycle 4.
- Intra-pair dependency: A writes r7, B reads ra2B=7, both valid -> grantA=1, grantB=0. After fire, cnt[7]=1.
- WAW and saturation (CNT_W=2):
  - A and B both write r9 for two cycles (advance=1) -> cnt[9] = 2, then 3 (B blocked once cnt+2 > 3).
  - Further writers to r9 -> grant deasserts. Two simultaneous writebacks to r9 -> cnt drops by 2.
- Simultaneous inc/dec: cnt[4]=1; A issues a write to r4 while wbEnB retires r4 -> cnt[4] stays 1, busy[4]=1.
- Register 0 and reset mid-flight:
  - Write r0 then read r0 -> grants stay 1, busy[0]=0.
  - With cnt[3]=2, assert reset -> busy=0 immediately.
  - Then wbEnA to r3 -> cnt[3] stays 0 and the underflow assertion is flagged.
